// File: rtl/axis_frame_arb_if.sv
// Stream bundle between NUM_SRC generators and one downstream consumer.
// The arbiter sits on the slave modport; the generator/consumer side uses master.
interface axis_frame_arb_if #(
    parameter int NUM_SRC = 4,
    parameter int DATAW   = 64
);
    logic [NUM_SRC-1:0]       s_vld;
    logic [NUM_SRC-1:0]       s_last;
    logic [NUM_SRC*DATAW-1:0] s_data;
    logic [NUM_SRC-1:0]       s_rdy;
    logic                     m_vld;
    logic                     m_last;
    logic [DATAW-1:0]         m_data;
    logic                     m_rdy;

    modport slave (
        input  s_vld, s_last, s_data, m_rdy,
        output s_rdy, m_vld, m_last, m_data
    );

    modport master (
        output s_vld, s_last, s_data, m_rdy,
        input  s_rdy, m_vld, m_last, m_data
    );
endinterface

// File: rtl/axis_frame_arb.sv
// Frame-atomic round-robin arbiter: one source owns the output from its first
// beat until its last-beat handshake, so frames never interleave.
// Optional feature: define AXIS_ARB_SRC_ID_EN to add the m_id output that
// tags each beat with the index of its source.
module axis_frame_arb #(
    parameter  int NUM_SRC = 4,
    parameter  int DATAW   = 64,
    localparam int IDW     = $clog2(NUM_SRC)
) (
    input  logic                  clk,
    input  logic                  s_rst_n,
    axis_frame_arb_if.slave       bus,
    output logic                  busy,
`ifdef AXIS_ARB_SRC_ID_EN
    output logic [IDW-1:0]        m_id,
`endif
    output logic [IDW-1:0]        grant
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [DATAW-1:0] src_data [NUM_SRC];
    logic             found;
    int               idx;

    // Unpack the flat data bus so the owner's word is selected by a plain index.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign src_data[i] = bus.s_data[i*DATAW +: DATAW];
    end

    // State and grant pointer registers; reset leaves source 0 first in line.
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            state_q <= IDLE;
            grant_q <= IDW'(NUM_SRC - 1);
        end else begin
            // NOTE: non-blocking here so every flop samples pre-edge values.
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Round-robin pick in IDLE, combinational pass-through of the owner in BUSY.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d    = state_q;
        grant_d    = grant_q;
        found      = 1'b0;
        idx        = 0;
        bus.m_vld  = 1'b0;
        bus.m_last = 1'b0;
        bus.m_data = '0;
        bus.s_rdy  = '0;
        // Outputs stay quiet during the reset cycle so no beat is forwarded
        // or accepted from a frame that reset is about to abandon.
        if (s_rst_n) begin
            unique case (state_q)
                IDLE: begin
                    for (int k = 1; k <= NUM_SRC; k++) begin
                        idx = (int'(grant_q) + k) % NUM_SRC;
                        if (!found && bus.s_vld[IDW'(idx)]) begin
                            found   = 1'b1;
                            grant_d = IDW'(idx);
                            state_d = BUSY;
                        end
                    end
                end
                BUSY: begin
                    bus.m_vld          = bus.s_vld[grant_q];
                    bus.m_last         = bus.s_last[grant_q];
                    bus.m_data         = src_data[grant_q];
                    bus.s_rdy[grant_q] = bus.m_rdy;
                    if (bus.m_vld && bus.m_rdy && bus.m_last) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy  = (state_q == BUSY);
    assign grant = grant_q;

`ifdef AXIS_ARB_SRC_ID_EN
    assign m_id = bus.m_vld ? grant_q : '0;
`endif

endmodule

// File: tb/tb_axis_frame_arb.sv
// Directed bench for axis_frame_arb (NUM_SRC=4, DATAW=64). Each source is a
// small frame generator whose beat counter advances on its own handshakes.
module tb_axis_frame_arb;

    localparam int NS = 4;
    localparam int DW = 64;

    logic       clk;
    logic       s_rst_n;
    logic       busy;
    logic [1:0] grant;
`ifdef AXIS_ARB_SRC_ID_EN
    logic [1:0] m_id;
`endif

    axis_frame_arb_if #(.NUM_SRC(NS), .DATAW(DW)) bus ();

    axis_frame_arb #(.NUM_SRC(NS), .DATAW(DW)) dut (
        .clk     (clk),
        .s_rst_n (s_rst_n),
        .bus     (bus),
        .busy    (busy),
`ifdef AXIS_ARB_SRC_ID_EN
        .m_id    (m_id),
`endif
        .grant   (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int beat   [NS];
    int flen   [NS];
    bit src_on [NS];

    function automatic logic [63:0] exp_data(int i, int b);
        return {8'(8'hA0 + i), 40'h0, 8'(i), 8'(b)};
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive every source from its generator state, then let logic settle.
    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            bus.s_vld[i]             = src_on[i];
            bus.s_last[i]            = (beat[i] == flen[i] - 1);
            bus.s_data[i*DW +: DW]   = exp_data(i, beat[i]);
        end
        #1;
    endtask

    // One clock: advance the beat counter of any source that handshook.
    task automatic cycle();
        logic [NS-1:0] hs;
        hs = bus.s_vld & bus.s_rdy;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (hs[i]) beat[i] = (beat[i] + 1) % flen[i];
        end
        drive();
    endtask

    task automatic do_reset(bit check_vals);
        s_rst_n   = 1'b0;
        bus.m_rdy = 1'b0;
        for (int i = 0; i < NS; i++) begin
            src_on[i] = 1'b0;
            beat[i]   = 0;
            flen[i]   = 1;
        end
        drive();
        cycle();
        cycle();
        if (check_vals) begin
            check("rst_busy",   64'(busy),       64'd0);
            check("rst_grant",  64'(grant),      64'd3);
            check("rst_m_vld",  64'(bus.m_vld),  64'd0);
            check("rst_m_last", 64'(bus.m_last), 64'd0);
            check("rst_m_data", bus.m_data,      64'd0);
            check("rst_s_rdy",  64'(bus.s_rdy),  64'd0);
        end
        s_rst_n = 1'b1;
        drive();
    endtask

    initial begin
        int hs_n;
        bus.s_vld  = '0;
        bus.s_last = '0;
        bus.s_data = '0;

        // Reset values.
        do_reset(1'b1);

        // Single source 2, 4-beat frames, m_rdy held high.
        flen[2] = 4; src_on[2] = 1'b1; bus.m_rdy = 1'b1;
        drive();
        check("a_idle_busy",  64'(busy),      64'd0);
        check("a_idle_m_vld", 64'(bus.m_vld), 64'd0);
        check("a_idle_s_rdy", 64'(bus.s_rdy), 64'd0);
        cycle();
        check("a_grant",  64'(grant),     64'd2);
        check("a_busy",   64'(busy),      64'd1);
        check("a_m_vld",  64'(bus.m_vld), 64'd1);
        check("a_b0",     bus.m_data,     exp_data(2, 0));
        check("a_s_rdy",  64'(bus.s_rdy), 64'b0100);
        for (int b = 1; b < 4; b++) begin
            cycle();
            check("a_beat", bus.m_data,       exp_data(2, b));
            check("a_last", 64'(bus.m_last),  64'(b == 3));
        end
        cycle();
        check("a_bubble_busy",  64'(busy),      64'd0);
        check("a_bubble_m_vld", 64'(bus.m_vld), 64'd0);
        cycle();
        check("a_f2_grant", 64'(grant), 64'd2);
        check("a_f2_b0",    bus.m_data, exp_data(2, 0));

        // All four sources, 3-beat frames: order 0,1,2,3,0 with one bubble each.
        do_reset(1'b0);
        for (int i = 0; i < NS; i++) begin
            flen[i] = 3; src_on[i] = 1'b1;
        end
        bus.m_rdy = 1'b1;
        drive();
        for (int c = 0; c < 20; c++) begin
            if (c % 4 == 0) begin
                check("b_bubble_m_vld", 64'(bus.m_vld), 64'd0);
                check("b_bubble_busy",  64'(busy),      64'd0);
            end else begin
                check("b_m_vld",  64'(bus.m_vld),  64'd1);
                check("b_m_data", bus.m_data,      exp_data((c / 4) % 4, (c % 4) - 1));
                check("b_m_last", 64'(bus.m_last), 64'((c % 4) == 3));
            end
            cycle();
        end

        // Source 1, 5-beat frame, m_rdy toggling 1010...
        do_reset(1'b0);
        flen[1] = 5; src_on[1] = 1'b1; bus.m_rdy = 1'b1;
        drive();
        cycle();
        hs_n = 0;
        for (int c = 0; c < 9; c++) begin
            bus.m_rdy = (c % 2 == 0);
            drive();
            check("c_m_data", bus.m_data,      exp_data(1, (c + 1) / 2));
            check("c_m_last", 64'(bus.m_last), 64'((c + 1) / 2 == 4));
            check("c_s_rdy",  64'(bus.s_rdy),  (c % 2 == 0) ? 64'b0010 : 64'b0000);
            if (bus.m_vld && bus.m_rdy) hs_n++;
            cycle();
        end
        check("c_handshakes", 64'(hs_n), 64'd5);
        check("c_end_busy",   64'(busy), 64'd0);

        // Owner 0 drops valid for 3 cycles while source 3 requests.
        do_reset(1'b0);
        flen[0] = 4; flen[3] = 2; src_on[0] = 1'b1; src_on[3] = 1'b1;
        bus.m_rdy = 1'b1;
        drive();
        cycle();
        check("d_grant0", 64'(grant), 64'd0);
        check("d_b0",     bus.m_data, exp_data(0, 0));
        cycle();
        src_on[0] = 1'b0;
        drive();
        for (int g = 0; g < 3; g++) begin
            check("d_gap_m_vld", 64'(bus.m_vld), 64'd0);
            check("d_gap_busy",  64'(busy),      64'd1);
            check("d_gap_grant", 64'(grant),     64'd0);
            check("d_gap_s_rdy", 64'(bus.s_rdy), 64'b0001);
            cycle();
        end
        src_on[0] = 1'b1;
        drive();
        check("d_b1", bus.m_data, exp_data(0, 1));
        cycle();
        check("d_b2", bus.m_data, exp_data(0, 2));
        cycle();
        check("d_b3",      bus.m_data,      exp_data(0, 3));
        check("d_b3_last", 64'(bus.m_last), 64'd1);
        cycle();
        check("d_bubble_busy", 64'(busy), 64'd0);
        cycle();
        check("d_grant3", 64'(grant), 64'd3);
        check("d_s3_b0",  bus.m_data, exp_data(3, 0));

        // Reset after two beats of an 8-beat frame from source 3.
        do_reset(1'b0);
        flen[3] = 8; src_on[3] = 1'b1; bus.m_rdy = 1'b1;
        drive();
        cycle();
        cycle();
        cycle();
        check("e_pre_b2", bus.m_data, exp_data(3, 2));
        s_rst_n = 1'b0;
        drive();
        check("e_rstcyc_m_vld", 64'(bus.m_vld), 64'd0);
        check("e_rstcyc_s_rdy", 64'(bus.s_rdy), 64'd0);
        cycle();
        check("e_post_busy",  64'(busy),      64'd0);
        check("e_post_m_vld", 64'(bus.m_vld), 64'd0);
        check("e_post_grant", 64'(grant),     64'd3);
        s_rst_n = 1'b1;
        for (int i = 0; i < NS; i++) beat[i] = 0;
        src_on[0] = 1'b1;
        drive();
        cycle();
        check("e_regrant", 64'(grant), 64'd0);
        check("e_b0",      bus.m_data, exp_data(0, 0));

`ifdef AXIS_ARB_SRC_ID_EN
        // Sources 1 and 2 alternating single-beat frames.
        do_reset(1'b0);
        src_on[1] = 1'b1; src_on[2] = 1'b1; bus.m_rdy = 1'b1;
        drive();
        for (int c = 0; c < 8; c++) begin
            if (c % 2 == 0) check("f_m_id_idle", 64'(m_id), 64'd0);
            else            check("f_m_id",      64'(m_id), (c % 4 == 1) ? 64'd1 : 64'd2);
            cycle();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
